encoder: RTL and testbench
==========================

ENCODER -- requirements
Module: encoder

Interface
REQ-001 The block SHALL have parameter LZ_SUPPRESS, default 1, meaning 1 = suppress leading zero hex digits (at least one digit always sent).
REQ-002 The block SHALL have parameter EOL_LF, default 1, meaning 1 = line ends with CR then LF, 0 = CR only.
REQ-003 The block SHALL have port clk  input  1  the single system clock, all logic rising-edge.
REQ-004 The block SHALL have port n_rst  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port start  input  1  one-cycle request to format the current result.
REQ-006 The block SHALL have port result  input  16  ALU result, hex-formatted.
REQ-007 The block SHALL have port data_type  input  4  one-hot I=8, F=4, U=2, S=1; only S changes formatting.
REQ-008 The block SHALL have port err  input  1  ALU error (e.g. divide by zero), sampled with start.
REQ-009 The block SHALL have port tx_data  output  8  ASCII byte offered to the UART transmitter.
REQ-010 The block SHALL have port tx_valid  output  1  tx_data is valid.
REQ-011 The block SHALL have port tx_ready  input  1  transmitter accepts the byte this cycle.
REQ-012 The block SHALL have port busy  output  1  a message is in progress.
REQ-013 The block SHALL have port done  output  1  one-cycle pulse after the last byte is accepted.

Function
REQ-014 A byte SHALL transfer on a rising clk edge where tx_valid and tx_ready are both 1.
REQ-015 tx_data SHALL remain stable while tx_valid=1 and tx_ready=0; tx_valid SHALL NOT drop before the transfer.
REQ-016 FSM SHALL have states IDLE, SEND; IDLE->SEND on start=1, SEND->IDLE on transfer of the final byte.
REQ-017 start in IDLE SHALL latch result, data_type, err; tx_valid SHALL be 1 with the first byte on the next cycle.
REQ-018 start while busy=1 SHALL be ignored, latched values unchanged.
REQ-019 busy SHALL equal (state==SEND).
REQ-020 Normal message SHALL be: optional '-' (0x2D), hex digits MSB-first, uppercase ('0'-'9'=0x30-0x39, 'A'-'F'=0x41-0x46), CR (0x0D), LF (0x0A) if EOL_LF=1.
REQ-021 If data_type[0]=1 and result[15]=1, '-' SHALL precede the digits of the 16-bit two's-complement magnitude; 0x8000 SHALL print as "-8000".
REQ-022 With LZ_SUPPRESS=1, leading zero nibbles SHALL be skipped, digit count = 1..4; value 0 SHALL print "0".
REQ-023 With LZ_SUPPRESS=0, exactly four digits SHALL be sent.
REQ-024 If err=1 at start, message SHALL be 'E','R','R' (0x45,0x52,0x52) then the line end, ignoring result and data_type.
REQ-025 Leading-zero count and magnitude SHALL be computed once at start-latch, not per byte.
REQ-026 done SHALL pulse for exactly one cycle, the cycle after the final byte transfer, concurrent with busy falling.
REQ-027 A start asserted in the cycle done=1 SHALL be accepted (state is IDLE).
REQ-028 tx_valid SHALL be 0 in IDLE; tx_data SHALL hold its last value in IDLE.

Reset
REQ-029 n_rst=0 SHALL immediately force state IDLE, tx_valid=0, tx_data=0x00, busy=0, done=0, byte index 0, latched values 0.
REQ-030 Reset mid-message SHALL abort it; no further bytes SHALL be offered after release until a new start.

Structure
REQ-031 ASCII constants (CR, LF, '-', 'E', 'R', '0', 'A') and data_type one-hot codes SHALL live in shared package alu_pkg, common with the decoder.
REQ-032 Nibble-to-ASCII conversion SHALL be a combinational sub-module hex2ascii (4-bit in, 8-bit out).

Verification
REQ-033 result=0x00A5, data_type=U, tx_ready=1 -> bytes 0x41,0x35,0x0D,0x0A on consecutive cycles, done pulse after 0x0A.
REQ-034 result=0x0000, LZ_SUPPRESS=1 -> 0x30,0x0D,0x0A; LZ_SUPPRESS=0 -> 0x30,0x30,0x30,0x30,0x0D,0x0A.
REQ-035 result=0xFFFE, data_type=S -> 0x2D,0x32,0x0D,0x0A; result=0x8000, S -> 0x2D,0x38,0x30,0x30,0x30,0x0D,0x0A.
REQ-036 err=1, result=0x1234 -> 0x45,0x52,0x52,0x0D,0x0A.
REQ-037 tx_ready low 5 cycles after first byte, start pulsed meanwhile -> tx_data/tx_valid frozen, message unchanged, no second message.
REQ-038 n_rst low during third byte -> tx_valid, busy, done, tx_data 0 immediately; idle after release until start.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU text constants and the encoder FSM type, common to the encoder and the decoder.
package alu_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_E     = 8'h45;
  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;

  localparam logic [3:0] DT_I = 4'b1000;
  localparam logic [3:0] DT_F = 4'b0100;
  localparam logic [3:0] DT_U = 4'b0010;
  localparam logic [3:0] DT_S = 4'b0001;

  typedef enum logic {
    ENC_IDLE = 1'b0,
    ENC_SEND = 1'b1
  } enc_state_e;

endpackage

// File: rtl/hex2ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
module hex2ascii
  import alu_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = ASCII_0 + {4'b0000, nibble};
    end else begin
      ascii = ASCII_A + {4'b0000, nibble - 4'd10};
    end
  end

endmodule

// File: rtl/encoder.sv
// Formats a latched 16-bit ALU result as an ASCII hex line and streams it
// over a valid/ready byte interface to the UART transmitter.
module encoder
  import alu_pkg::*;
#(
  parameter bit LZ_SUPPRESS = 1'b1,
  parameter bit EOL_LF      = 1'b1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [15:0] result,
  input  logic [3:0]  data_type,
  input  logic        err,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] EOL_BYTES = EOL_LF ? 3'd2 : 3'd1;

  enc_state_e  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        neg_q, neg_d;
  logic        err_q, err_d;
  logic [15:0] mag_q, mag_d;
  logic [2:0]  ndig_q, ndig_d;
  logic [2:0]  len_q, len_d;
  logic [7:0]  last_q, last_d;
  logic        done_q, done_d;

  logic        lat_neg;
  logic [15:0] lat_mag;
  logic [2:0]  lat_ndig;
  logic [2:0]  lat_len;

  logic [2:0]  pos;
  logic [1:0]  nib_sel;
  logic [3:0]  nibble;
  logic [7:0]  hex_char;
  logic [7:0]  cur_byte;
  logic        last_byte;

  // Everything the byte sequencer needs is derived once here, at start-latch.
  // For an error message the three letters occupy the digit slots.
  always_comb begin
    lat_neg  = ~err & ((data_type & DT_S) != 4'b0000) & result[15];
    lat_mag  = lat_neg ? (~result + 16'd1) : result;
    lat_ndig = 3'd4;
    if (err) begin
      lat_mag  = 16'h0000;
      lat_ndig = 3'd3;
    end else if (LZ_SUPPRESS) begin
      if (lat_mag[15:12] != 4'h0)     lat_ndig = 3'd4;
      else if (lat_mag[11:8] != 4'h0) lat_ndig = 3'd3;
      else if (lat_mag[7:4] != 4'h0)  lat_ndig = 3'd2;
      else                            lat_ndig = 3'd1;
    end
    lat_len = {2'b00, lat_neg} + lat_ndig + EOL_BYTES;
  end

  always_comb begin
    pos     = idx_q - {2'b00, neg_q};
    nib_sel = 2'(ndig_q - 3'd1 - pos);
    case (nib_sel)
      2'd0:    nibble = mag_q[3:0];
      2'd1:    nibble = mag_q[7:4];
      2'd2:    nibble = mag_q[11:8];
      default: nibble = mag_q[15:12];
    endcase
  end

  hex2ascii u_hex2ascii (
    .nibble (nibble),
    .ascii  (hex_char)
  );

  always_comb begin
    if (neg_q && (idx_q == 3'd0)) begin
      cur_byte = ASCII_MINUS;
    end else if (pos < ndig_q) begin
      if (err_q) cur_byte = (pos == 3'd0) ? ASCII_E : ASCII_R;
      else       cur_byte = hex_char;
    end else if (pos == ndig_q) begin
      cur_byte = ASCII_CR;
    end else begin
      cur_byte = ASCII_LF;
    end
    last_byte = (idx_q == (len_q - 3'd1));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    neg_d   = neg_q;
    err_d   = err_q;
    mag_d   = mag_q;
    ndig_d  = ndig_q;
    len_d   = len_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      ENC_IDLE: begin
        if (start) begin
          state_d = ENC_SEND;
          idx_d   = 3'd0;
          neg_d   = lat_neg;
          err_d   = err;
          mag_d   = lat_mag;
          ndig_d  = lat_ndig;
          len_d   = lat_len;
        end
      end
      ENC_SEND: begin
        if (tx_ready) begin
          last_d = cur_byte;
          if (last_byte) begin
            state_d = ENC_IDLE;
            idx_d   = 3'd0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = ENC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ENC_IDLE;
      idx_q   <= 3'd0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      mag_q   <= 16'h0000;
      ndig_q  <= 3'd0;
      len_q   <= 3'd0;
      last_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      mag_q   <= mag_d;
      ndig_q  <= ndig_d;
      len_q   <= len_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // Outside a message the line shows the last byte sent (0x00 after reset).
  assign tx_valid = (state_q == ENC_SEND);
  assign busy     = (state_q == ENC_SEND);
  assign tx_data  = (state_q == ENC_SEND) ? cur_byte : last_q;
  assign done     = done_q;

endmodule

// File: tb/tb_encoder.sv
// Randomised and directed bench for encoder: two instances (default and
// four-digit/CR-only) checked against a string-level reference model.
module tb_encoder;

  logic clk = 1'b0;
  logic n_rst;
  logic [1:0]       start_v, err_v, rdy_v, valid_v, busy_v, done_v;
  logic [1:0][15:0] result_v;
  logic [1:0][3:0]  dt_v;
  logic [1:0][7:0]  data_v;

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  encoder dut (
    .clk(clk), .n_rst(n_rst), .start(start_v[0]), .result(result_v[0]),
    .data_type(dt_v[0]), .err(err_v[0]), .tx_data(data_v[0]), .tx_valid(valid_v[0]),
    .tx_ready(rdy_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );

  encoder #(.LZ_SUPPRESS(1'b0), .EOL_LF(1'b0)) dut_raw (
    .clk(clk), .n_rst(n_rst), .start(start_v[1]), .result(result_v[1]),
    .data_type(dt_v[1]), .err(err_v[1]), .tx_data(data_v[1]), .tx_valid(valid_v[1]),
    .tx_ready(rdy_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Expected text of a message, built from the value as a signed/unsigned number.
  task automatic build_model(input logic [15:0] res, input logic [3:0] dt, input bit e,
                             input bit lz, input bit eol);
    int v, nd, dig;
    string s;
    exp_q.delete();
    if (e) begin
      s = "ERR";
      for (int i = 0; i < 3; i++) exp_q.push_back(s[i]);
    end else begin
      v = dt[0] ? int'($signed(res)) : int'(res);
      if (v < 0) begin
        exp_q.push_back(8'h2D);
        v = -v;
      end
      nd = lz ? 1 : 4;
      while (nd < 4 && (v >> (4 * nd)) != 0) nd++;
      for (int k = nd - 1; k >= 0; k--) begin
        dig = (v >> (4 * k)) % 16;
        exp_q.push_back(8'(dig < 10 ? 48 + dig : 55 + dig));
      end
    end
    exp_q.push_back(8'h0D);
    if (eol) exp_q.push_back(8'h0A);
  endtask

  function automatic logic [3:0] rand_type();
    case ($urandom_range(0, 3))
      0:       return 4'b1000;
      1:       return 4'b0100;
      2:       return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  // mode 0: always ready; 1: random ready; 2: ready low 5 cycles after first byte.
  task automatic run_msg(input int inst, input logic [15:0] res, input logic [3:0] dt,
                         input bit e, input int mode, input bit b2b);
    int got, cyc;
    bit rdy;
    build_model(res, dt, e, inst == 0, inst == 0);
    start_v[inst] = 1'b1;
    result_v[inst] = res;
    dt_v[inst] = dt;
    err_v[inst] = e;
    @(negedge clk);
    start_v[inst] = 1'b0;
    check("first_valid", 16'(valid_v[inst]), 16'd1);
    got = 0;
    cyc = 0;
    while (got < exp_q.size() && cyc < 300) begin
      check("valid_hold", 16'(valid_v[inst]), 16'd1);
      check("busy_high", 16'(busy_v[inst]), 16'd1);
      check("done_low", 16'(done_v[inst]), 16'd0);
      check($sformatf("i%0d_byte%0d", inst, got), 16'(data_v[inst]), 16'(exp_q[got]));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (cyc == 0) || (cyc >= 6);
      endcase
      rdy_v[inst] = rdy;
      if (mode != 0 && !rdy) begin
        start_v[inst] = 1'($urandom_range(0, 1));
        result_v[inst] = 16'($urandom);
        dt_v[inst] = rand_type();
        err_v[inst] = 1'($urandom_range(0, 1));
      end else begin
        start_v[inst] = 1'b0;
      end
      if (rdy) got++;
      @(negedge clk);
      cyc++;
    end
    start_v[inst] = 1'b0;
    check("byte_count", 16'(got), 16'(exp_q.size()));
    check("done_pulse", 16'(done_v[inst]), 16'd1);
    check("busy_fall", 16'(busy_v[inst]), 16'd0);
    check("valid_idle", 16'(valid_v[inst]), 16'd0);
    check("data_hold", 16'(data_v[inst]), 16'(exp_q[exp_q.size() - 1]));
    if (!b2b) begin
      rdy_v[inst] = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("done_once", 16'(done_v[inst]), 16'd0);
      check("no_second_msg", 16'(valid_v[inst]), 16'd0);
    end
  endtask

  initial begin
    logic [15:0] mask, r;
    n_rst = 1'b0;
    start_v = '0; err_v = '0; rdy_v = '0;
    result_v = '0; dt_v = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_valid", 16'(valid_v[i]), 16'd0);
      check("rst_busy", 16'(busy_v[i]), 16'd0);
      check("rst_done", 16'(done_v[i]), 16'd0);
      check("rst_data", 16'(data_v[i]), 16'h0000);
    end
    n_rst = 1'b1;
    @(negedge clk);

    run_msg(0, 16'h00A5, 4'b0010, 1'b0, 0, 1'b0);
    run_msg(0, 16'h0000, 4'b0010, 1'b0, 0, 1'b0);
    run_msg(1, 16'h0000, 4'b0010, 1'b0, 0, 1'b0);
    run_msg(0, 16'hFFFE, 4'b0001, 1'b0, 0, 1'b0);
    run_msg(0, 16'h8000, 4'b0001, 1'b0, 0, 1'b0);
    run_msg(0, 16'h8000, 4'b0010, 1'b0, 0, 1'b0);
    run_msg(1, 16'hFFFE, 4'b0001, 1'b0, 0, 1'b0);
    run_msg(0, 16'h1234, 4'b0001, 1'b1, 0, 1'b0);
    run_msg(1, 16'h1234, 4'b1000, 1'b1, 0, 1'b0);
    run_msg(0, 16'h3C07, 4'b0100, 1'b0, 2, 1'b0);
    run_msg(0, 16'h0F00, 4'b0010, 1'b0, 0, 1'b1);
    run_msg(0, 16'h9001, 4'b0001, 1'b0, 0, 1'b0);

    // Reset while the third byte is being offered.
    build_model(16'h1234, 4'b0010, 1'b0, 1'b1, 1'b1);
    start_v[0] = 1'b1; result_v[0] = 16'h1234; dt_v[0] = 4'b0010; err_v[0] = 1'b0;
    rdy_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    rdy_v[0] = 1'b0;
    check("third_byte", 16'(data_v[0]), 16'(exp_q[2]));
    n_rst = 1'b0;
    #1;
    check("abort_valid", 16'(valid_v[0]), 16'd0);
    check("abort_busy", 16'(busy_v[0]), 16'd0);
    check("abort_done", 16'(done_v[0]), 16'd0);
    check("abort_data", 16'(data_v[0]), 16'h0000);
    @(negedge clk);
    n_rst = 1'b1;
    rdy_v[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_idle", 16'(valid_v[0]), 16'd0);
      check("post_rst_busy", 16'(busy_v[0]), 16'd0);
    end

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 4))
        0:       mask = 16'h000F;
        1:       mask = 16'h00FF;
        2:       mask = 16'h0FFF;
        default: mask = 16'hFFFF;
      endcase
      r = 16'($urandom) & mask;
      if ($urandom_range(0, 5) == 0) r = r | 16'h8000;
      run_msg(n % 2, r, rand_type(), $urandom_range(0, 7) == 0,
              int'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
